// File: rtl/mmio_console_bridge.sv
// mmio_console_bridge
//   Peripheral-side end of the data memory's MMIO console words. Host words
//   arrive on a valid/ready stream, are buffered in an RX FIFO and shown to the
//   CPU one at a time. Words the CPU publishes are captured into a TX FIFO and
//   drained to the host on a valid/ready stream. Neither side can clear the
//   other's register, so each direction uses a toggle handshake carried in the
//   ready words.
//
//   Optional feature macro: MMIO_BRIDGE_STATUS_EN (adds FIFO status bits to
//   input_ready; when undefined input_ready[BUS_WIDTH-1:2] is constant 0).
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   output_data     CPU-written word to forward to the host
//   output_ready    CPU control: [0] tx_tog, [1] rx_ack_tog, rest ignored
//   input_data      word presented to the CPU (registered)
//   input_ready     bridge control: [0] rx_tog, [1] tx_ack_tog (registered)
//                   with status: [2] TX full, [3] RX non-empty, [11:8] RX count
//   host_rx_*       host -> CPU stream (data, valid, ready)
//   host_tx_*       CPU -> host stream (data, valid, ready)
module mmio_console_bridge #(
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] output_data,
  input  logic [BUS_WIDTH-1:0] output_ready,
  output logic [BUS_WIDTH-1:0] input_data,
  output logic [BUS_WIDTH-1:0] input_ready,
  input  logic [BUS_WIDTH-1:0] host_rx_data,
  input  logic                 host_rx_valid,
  output logic                 host_rx_ready,
  output logic [BUS_WIDTH-1:0] host_tx_data,
  output logic                 host_tx_valid,
  input  logic                 host_tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {RX_IDLE, RX_WAIT} rx_state_e;

  logic [BUS_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic                 rx_push, rx_pop, tx_push, tx_pop;

  rx_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0] input_data_q, input_data_d;
  logic                 rx_tog_q, rx_tog_d;
  logic                 tx_ack_tog_q, tx_ack_tog_d;

  // Only the two toggle bits of the CPU control word carry meaning.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^output_ready[BUS_WIDTH-1:2];

  // Pointers carry one extra wrap bit: equal -> empty, differing only in the
  // wrap bit -> full.
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

  // Push is gated on the registered full flag, so a same-cycle pop never
  // lets a write into a full FIFO.
  assign host_rx_ready = !rx_full;
  assign rx_push       = host_rx_valid && !rx_full;

  assign host_tx_valid = !tx_empty;
  assign host_tx_data  = tx_mem_q[tx_rd_q[AW-1:0]];
  assign tx_pop        = !tx_empty && host_tx_ready;

  // A fresh CPU word is detected against our own ack register, so the MMIO
  // read-back lag cannot produce a second capture of the same word.
  assign tx_push       = (output_ready[0] != tx_ack_tog_q) && !tx_full;
  assign tx_ack_tog_d  = tx_ack_tog_q ^ tx_push;

  assign rx_wr_d = rx_wr_q + {{AW{1'b0}}, rx_push};
  assign rx_rd_d = rx_rd_q + {{AW{1'b0}}, rx_pop};
  assign tx_wr_d = tx_wr_q + {{AW{1'b0}}, tx_push};
  assign tx_rd_d = tx_rd_q + {{AW{1'b0}}, tx_pop};

  // RX presentation: one word in flight to the CPU; the next pop waits until
  // the CPU's ack toggle matches rx_tog and the FSM is back in RX_IDLE.
  always_comb begin
    state_d      = state_q;
    rx_pop       = 1'b0;
    input_data_d = input_data_q;
    rx_tog_d     = rx_tog_q;
    case (state_q)
      RX_IDLE: begin
        if (!rx_empty) begin
          rx_pop       = 1'b1;
          input_data_d = rx_mem_q[rx_rd_q[AW-1:0]];
          rx_tog_d     = ~rx_tog_q;
          state_d      = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (output_ready[1] == rx_tog_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      input_data_q <= '0;
      rx_tog_q     <= 1'b0;
      tx_ack_tog_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      input_data_q <= input_data_d;
      rx_tog_q     <= rx_tog_d;
      tx_ack_tog_q <= tx_ack_tog_d;
    end
  end

  // FIFO storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= host_rx_data;
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= output_data;
  end

  assign input_data = input_data_q;

`ifdef MMIO_BRIDGE_STATUS_EN
  logic [BUS_WIDTH-1:0] status_q, status_d;
  logic [PW-1:0]        rx_count;

  assign rx_count = rx_wr_q - rx_rd_q;

  always_comb begin
    status_d       = '0;
    status_d[2]    = tx_full;
    status_d[3]    = !rx_empty;
    status_d[11:8] = 4'(rx_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= status_d;
  end

  assign input_ready = status_q | {{(BUS_WIDTH-2){1'b0}}, tx_ack_tog_q, rx_tog_q};
`else
  assign input_ready = {{(BUS_WIDTH-2){1'b0}}, tx_ack_tog_q, rx_tog_q};
`endif

endmodule

// File: tb/tb_mmio_console_bridge.sv
// Scoreboard bench for mmio_console_bridge: stimulus pushes expected words into
// per-direction queues; a CPU-model process and a host-side monitor pop and
// compare whenever the bridge presents a word.
module tb_mmio_console_bridge;
  localparam int BW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] output_data, output_ready;
  logic [BW-1:0] input_data, input_ready;
  logic [BW-1:0] host_rx_data;
  logic          host_rx_valid, host_rx_ready;
  logic [BW-1:0] host_tx_data;
  logic          host_tx_valid, host_tx_ready;

  bit            rx_ack_bit = 1'b0;
  bit            tx_tog_bit = 1'b0;
  assign output_ready = {30'd0, rx_ack_bit, tx_tog_bit};

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [BW-1:0] rx_exp[$];
  logic [BW-1:0] tx_exp[$];
  bit            cpu_ack_en     = 1'b1;
  int            cpu_hold_max   = 0;
  int            tx_rdy_mode    = 0;
  int            tx_valid_cycles = 0;

  mmio_console_bridge #(.BUS_WIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .output_data  (output_data),
    .output_ready (output_ready),
    .input_data   (input_data),
    .input_ready  (input_ready),
    .host_rx_data (host_rx_data),
    .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .host_tx_data (host_tx_data),
    .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // CPU model: sees a pending word when rx_tog differs from its ack bit,
  // checks it against the scoreboard, holds, then acknowledges.
  initial begin : cpu_rx
    logic [BW-1:0] cur;
    bit            seen;
    int            hold;
    cur = '0; seen = 1'b0; hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_ack_bit = 1'b0;
        seen = 1'b0;
        hold = 0;
      end else if (input_ready[0] != rx_ack_bit) begin
        if (!seen) begin
          seen = 1'b1;
          cur  = input_data;
          hold = (cpu_hold_max > 0) ? int'($urandom_range(cpu_hold_max, 0)) : 0;
          if (rx_exp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rx_spurious: got 0x%08h expected no word", input_data);
          end else begin
            chk("rx_word", input_data, rx_exp.pop_front());
          end
        end else begin
          chk("rx_hold", input_data, cur);
        end
        if (cpu_ack_en) begin
          if (hold == 0) begin
            rx_ack_bit = ~rx_ack_bit;
            seen = 1'b0;
          end else begin
            hold--;
          end
        end
      end
    end
  end

  // Host-side TX monitor.
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (rst_n && host_tx_valid) begin
        tx_valid_cycles++;
        if (host_tx_ready) begin
          if (tx_exp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL tx_spurious: got 0x%08h expected no word", host_tx_data);
          end else begin
            chk("tx_word", host_tx_data, tx_exp.pop_front());
          end
        end
      end
    end
  end

  // host_tx_ready driver: 0 = hold off, 1 = always ready, 2 = random.
  initial begin : tx_rdy_drv
    host_tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_rdy_mode)
        0:       host_tx_ready = 1'b0;
        1:       host_tx_ready = 1'b1;
        default: host_tx_ready = (($urandom % 2) == 1);
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic host_send(input logic [BW-1:0] w, input int maxwait, output bit ok);
    host_rx_data  = w;
    host_rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < maxwait && !ok; i++) begin
      @(negedge clk);
      if (host_rx_ready) begin
        rx_exp.push_back(w);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    host_rx_valid = 1'b0;
  endtask

  task automatic tx_wait_ack(input int maxwait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxwait && !ok; i++) begin
      @(posedge clk); #1;
      if (input_ready[1] == tx_tog_bit) ok = 1'b1;
    end
  endtask

  // Data is written one cycle before the toggle flips and held until acked.
  task automatic cpu_send(input logic [BW-1:0] w, input int maxwait, output bit ok);
    output_data = w;
    @(posedge clk); #1;
    tx_exp.push_back(w);
    tx_tog_bit = ~tx_tog_bit;
    tx_wait_ack(maxwait, ok);
  endtask

  initial begin : main
    bit ok;
    rst_n = 1'b0;
    host_rx_valid = 1'b0;
    host_rx_data  = '0;
    output_data   = '0;

    // Reset state
    tick(3);
    chk("rst_input_ready", input_ready, 32'h0);
    chk("rst_input_data", input_data, 32'h0);
    chk("rst_tx_valid", 32'(host_tx_valid), 32'h0);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_input_ready", input_ready, 32'h0);
    chk("post_rst_input_data", input_data, 32'h0);
    chk("post_rst_rx_ready", 32'(host_rx_ready), 32'h1);
    chk("post_rst_tx_valid", 32'(host_tx_valid), 32'h0);

    // Single RX word, CPU holding its ack
    cpu_ack_en = 1'b0;
    host_send(32'hDEADBEEF, 5, ok);
    chk("rx1_accept", 32'(ok), 32'h1);
    chk("rx1_not_yet", 32'(input_ready[0]), 32'h0);
    tick(1);
    chk("rx1_data", input_data, 32'hDEADBEEF);
    chk("rx1_tog", 32'(input_ready[0]), 32'h1);
    tick(4);
    chk("rx1_held", input_data, 32'hDEADBEEF);
    cpu_ack_en = 1'b1;
    tick(6);
    chk("rx1_tog_after_ack", 32'(input_ready[0]), 32'h1);
    chk("rx1_queue_empty", 32'(rx_exp.size()), 32'h0);

    // Five words against a four-deep FIFO with no ack
    cpu_ack_en = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      host_send(32'(w), 5, ok);
      chk("rx5_accept", 32'(ok), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rx5_backpressure", 32'(host_rx_ready), 32'h0);
    end
    @(posedge clk); #1;
    cpu_ack_en = 1'b1;
    for (int i = 0; i < 60 && rx_exp.size() != 0; i++) tick(1);
    tick(4);
    chk("rx5_drained", 32'(rx_exp.size()), 32'h0);
    chk("rx5_rx_ready", 32'(host_rx_ready), 32'h1);

    // Single TX word, host always ready
    tx_rdy_mode = 1;
    tick(2);
    tx_valid_cycles = 0;
    cpu_send(32'h12345678, 5, ok);
    chk("tx1_acked", 32'(ok), 32'h1);
    tick(4);
    chk("tx1_valid_cycles", 32'(tx_valid_cycles), 32'h1);
    chk("tx1_ack_tog", 32'(input_ready[1]), 32'h1);
    chk("tx1_queue_empty", 32'(tx_exp.size()), 32'h0);

    // TX FIFO full stalls the fifth word until the host pops
    tx_rdy_mode = 0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      cpu_send(32'hA0 + 32'(i), 5, ok);
      chk("txf_acked", 32'(ok), 32'h1);
    end
    cpu_send(32'hA4, 8, ok);
    chk("txf_fifth_stalled", 32'(ok), 32'h0);
    chk("txf_head_valid", 32'(host_tx_valid), 32'h1);
    chk("txf_head_data", host_tx_data, 32'hA0);
    tx_rdy_mode = 1;
    tx_wait_ack(10, ok);
    chk("txf_fifth_acked", 32'(ok), 32'h1);
    tick(10);
    chk("txf_drained", 32'(tx_exp.size()), 32'h0);

    // Asynchronous reset while a word is shown and two are buffered
    cpu_ack_en = 1'b0;
    host_send(32'h111, 5, ok);
    chk("rr_accept", 32'(ok), 32'h1);
    host_send(32'h222, 5, ok);
    chk("rr_accept", 32'(ok), 32'h1);
    host_send(32'h333, 5, ok);
    chk("rr_accept", 32'(ok), 32'h1);
    tick(3);
    chk("rr_presented", input_data, 32'h111);
    @(posedge clk); #3;
    rst_n = 1'b0;
    tx_tog_bit = 1'b0;
    #1;
    chk("rr_input_ready", input_ready, 32'h0);
    chk("rr_input_data", input_data, 32'h0);
    chk("rr_rx_ready", 32'(host_rx_ready), 32'h1);
    chk("rr_tx_valid", 32'(host_tx_valid), 32'h0);
    rx_exp.delete();
    tx_exp.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cpu_ack_en = 1'b1;
    tick(10);
    chk("rr_no_stale_ready", input_ready, 32'h0);
    chk("rr_no_stale_data", input_data, 32'h0);
    chk("rr_no_stale_tx", 32'(host_tx_valid), 32'h0);

    // Randomised traffic in both directions
    cpu_hold_max = 3;
    tx_rdy_mode  = 2;
    fork
      begin
        bit okr;
        for (int i = 0; i < 30; i++) begin
          tick(1 + int'($urandom_range(2, 0)));
          host_send($urandom, 200, okr);
          chk("rnd_rx_accept", 32'(okr), 32'h1);
        end
      end
      begin
        bit okt;
        for (int i = 0; i < 30; i++) begin
          tick(1 + int'($urandom_range(2, 0)));
          cpu_send($urandom, 200, okt);
          chk("rnd_tx_acked", 32'(okt), 32'h1);
        end
      end
    join
    tx_rdy_mode = 1;
    for (int i = 0; i < 200 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) tick(1);
    tick(4);
    chk("rnd_rx_drained", 32'(rx_exp.size()), 32'h0);
    chk("rnd_tx_drained", 32'(tx_exp.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
